iter_divider: RTL and testbench

//  Multi-cycle restoring divider for DIV/DIVU in the 54-instruction CPU. Sits upstream of the
//  32-bit 8:1 write-back select mux, which picks quotient (LO) or remainder (HI) through its
//  3-bit select. The controller pulses start, then stalls the pipeline on busy until done.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 29 ++
 rtl/iter_divider.sv | 135 +++++++++++++
 tb/tb_iter_divider.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  localparam int DIV_W = 32;
  localparam int CNT_W = $clog2(DIV_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, and record the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] dvs_ext;

  // Remainder is one bit wider than the divisor so the shifted value never overflows.
  assign shifted = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
  assign dvs_ext = {1'b0, dvs_i};

  always_comb begin
    rem_o = shifted;
    quo_o = {quo_i[WIDTH-2:0], 1'b0};
    if (shifted >= dvs_ext) begin
      rem_o = shifted - dvs_ext;
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle signed/unsigned restoring divider (DIV/DIVU), one quotient bit per cycle.
// Optional macro DIV_BYZERO_DETECT_EN: short-circuit divide-by-zero and raise dbz.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Operands are reduced to magnitudes at launch; signs are re-applied at the end.
  assign sgn_a = is_signed & dividend[WIDTH-1];
  assign sgn_b = is_signed & divisor[WIDTH-1];
  assign mag_a = sgn_a ? -dividend : dividend;
  assign mag_b = sgn_b ? -divisor : divisor;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
`ifdef DIV_BYZERO_DETECT_EN
          if (divisor == '0) begin
            state_d = S_DONE;
            q_d     = '1;
            r_d     = dividend;
            dbz_d   = 1'b1;
          end else begin
`endif
            state_d = S_CALC;
            cnt_d   = CW'(WIDTH - 1);
            rem_d   = '0;
            quo_d   = mag_a;
            dvs_d   = mag_b;
            negq_d  = sgn_a ^ sgn_b;
            negr_d  = sgn_a;
`ifdef DIV_BYZERO_DETECT_EN
          end
`endif
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = S_DONE;
          q_d     = negq_q ? -step_quo : step_quo;
          r_d     = negr_q ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy = (state_q == S_CALC);
  assign done = (state_q == S_DONE);
  assign q    = q_q;
  assign r    = r_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed self-checking bench for iter_divider: latency, signed/unsigned results,
// boundaries, divide-by-zero, ignored restart, back-to-back issue and mid-divide reset.
module tb_iter_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        dbz;

  int n_cmp;
  int n_err;

  iter_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .q         (q),
    .r         (r),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one divide and wait for done; lat counts edges from the sampling edge (1) onward.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output logic [31:0] gq, output logic [31:0] gr, output logic gdbz,
                        output int lat, output int bc);
    @(negedge clk);
    dividend = a; divisor = b; is_signed = sgn; start = 1'b1;
    lat = -1; bc = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bc++;
      if (done) begin
        lat = c;
        break;
      end
    end
    gq = q; gr = r; gdbz = dbz;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (q !== 32'h0) begin n_err++; $display("FAIL reset_q got=%h exp=0", q); end
    n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL reset_r got=%h exp=0", r); end
    n_cmp++; if (dbz !== 1'b0) begin n_err++; $display("FAIL reset_dbz got=%b exp=0", dbz); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu();
    logic [31:0] gq, gr; logic gd; int lat, bc;
    do_div(32'd100, 32'd7, 1'b0, gq, gr, gd, lat, bc);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL divu_latency got=%0d exp=33", lat); end
    n_cmp++; if (bc !== 32) begin n_err++; $display("FAIL divu_busy_cycles got=%0d exp=32", bc); end
    n_cmp++; if (gq !== 32'd14) begin n_err++; $display("FAIL divu_q got=%h exp=%h", gq, 32'd14); end
    n_cmp++; if (gr !== 32'd2) begin n_err++; $display("FAIL divu_r got=%h exp=%h", gr, 32'd2); end
    n_cmp++; if (gd !== 1'b0) begin n_err++; $display("FAIL divu_dbz got=%b exp=0", gd); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse got=%b exp=0", done); end
    n_cmp++; if (q !== 32'd14) begin n_err++; $display("FAIL q_hold got=%h exp=%h", q, 32'd14); end
    do_div(32'hFFFF_FFF9, 32'd2, 1'b0, gq, gr, gd, lat, bc);
    n_cmp++; if (gq !== 32'h7FFF_FFFC) begin n_err++; $display("FAIL divu_big_q got=%h exp=7ffffffc", gq); end
    n_cmp++; if (gr !== 32'd1) begin n_err++; $display("FAIL divu_big_r got=%h exp=1", gr); end
  endtask

  task automatic test_signed();
    logic [31:0] gq, gr; logic gd; int lat, bc;
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, gq, gr, gd, lat, bc);
    n_cmp++; if (gq !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_m7_2_q got=%h exp=fffffffd", gq); end
    n_cmp++; if (gr !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_m7_2_r got=%h exp=ffffffff", gr); end
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL div_latency got=%0d exp=33", lat); end
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, gq, gr, gd, lat, bc);
    n_cmp++; if (gq !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_7_m2_q got=%h exp=fffffffd", gq); end
    n_cmp++; if (gr !== 32'd1) begin n_err++; $display("FAIL div_7_m2_r got=%h exp=1", gr); end
    do_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, gq, gr, gd, lat, bc);
    n_cmp++; if (gq !== 32'd3) begin n_err++; $display("FAIL div_m7_m2_q got=%h exp=3", gq); end
    n_cmp++; if (gr !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_m7_m2_r got=%h exp=ffffffff", gr); end
  endtask

  task automatic test_boundary();
    logic [31:0] gq, gr; logic gd; int lat, bc;
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, gq, gr, gd, lat, bc);
    n_cmp++; if (gq !== 32'h8000_0000) begin n_err++; $display("FAIL intmin_q got=%h exp=80000000", gq); end
    n_cmp++; if (gr !== 32'h0) begin n_err++; $display("FAIL intmin_r got=%h exp=0", gr); end
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0, gq, gr, gd, lat, bc);
    n_cmp++; if (gq !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divu_max_q got=%h exp=ffffffff", gq); end
    n_cmp++; if (gr !== 32'h0) begin n_err++; $display("FAIL divu_max_r got=%h exp=0", gr); end
    do_div(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, gq, gr, gd, lat, bc);
    n_cmp++; if (gq !== 32'd1) begin n_err++; $display("FAIL divu_near_q got=%h exp=1", gq); end
    n_cmp++; if (gr !== 32'd1) begin n_err++; $display("FAIL divu_near_r got=%h exp=1", gr); end
  endtask

  task automatic test_div_by_zero();
    logic [31:0] gq, gr; logic gd; int lat, bc;
    logic [31:0] exp_sq;
    int exp_lat;
    logic exp_dbz;
`ifdef DIV_BYZERO_DETECT_EN
    exp_lat = 1;  exp_dbz = 1'b1; exp_sq = 32'hFFFF_FFFF;
`else
    exp_lat = 33; exp_dbz = 1'b0; exp_sq = 32'h0000_0001;
`endif
    do_div(32'd5, 32'd0, 1'b0, gq, gr, gd, lat, bc);
    n_cmp++; if (lat !== exp_lat) begin n_err++; $display("FAIL dbz_latency got=%0d exp=%0d", lat, exp_lat); end
    n_cmp++; if (gq !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dbz_q got=%h exp=ffffffff", gq); end
    n_cmp++; if (gr !== 32'd5) begin n_err++; $display("FAIL dbz_r got=%h exp=5", gr); end
    n_cmp++; if (gd !== exp_dbz) begin n_err++; $display("FAIL dbz_flag got=%b exp=%b", gd, exp_dbz); end
    do_div(32'hFFFF_FFFB, 32'd0, 1'b1, gq, gr, gd, lat, bc);
    n_cmp++; if (gq !== exp_sq) begin n_err++; $display("FAIL dbz_signed_q got=%h exp=%h", gq, exp_sq); end
    n_cmp++; if (gr !== 32'hFFFF_FFFB) begin n_err++; $display("FAIL dbz_signed_r got=%h exp=fffffffb", gr); end
    do_div(32'd9, 32'd3, 1'b0, gq, gr, gd, lat, bc);
    n_cmp++; if (gd !== 1'b0) begin n_err++; $display("FAIL dbz_clear got=%b exp=0", gd); end
    n_cmp++; if (gq !== 32'd3) begin n_err++; $display("FAIL dbz_after_q got=%h exp=3", gq); end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = (c == 10);
      if (c == 10) begin dividend = 32'd50; divisor = 32'd3; end
      if (done) begin lat = c; break; end
    end
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL ignore_latency got=%0d exp=33", lat); end
    n_cmp++; if (q !== 32'd14) begin n_err++; $display("FAIL ignore_q got=%h exp=%h", q, 32'd14); end
    n_cmp++; if (r !== 32'd2) begin n_err++; $display("FAIL ignore_r got=%h exp=2", r); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_idle got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int first, second;
    logic [31:0] fq, fr;
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    first = -1; second = -1; fq = '0; fr = '0;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (done && first < 0) begin
        first = c; fq = q; fr = r;
        dividend = 32'd9; divisor = 32'd4;
      end else if (done) begin
        second = c;
        start = 1'b0;
        break;
      end
    end
    n_cmp++; if (first !== 33) begin n_err++; $display("FAIL b2b_first_latency got=%0d exp=33", first); end
    n_cmp++; if (fq !== 32'd14) begin n_err++; $display("FAIL b2b_first_q got=%h exp=%h", fq, 32'd14); end
    n_cmp++; if (fr !== 32'd2) begin n_err++; $display("FAIL b2b_first_r got=%h exp=2", fr); end
    n_cmp++; if (second !== 66) begin n_err++; $display("FAIL b2b_second_latency got=%0d exp=66", second); end
    n_cmp++; if (q !== 32'd2) begin n_err++; $display("FAIL b2b_second_q got=%h exp=2", q); end
    n_cmp++; if (r !== 32'd1) begin n_err++; $display("FAIL b2b_second_r got=%h exp=1", r); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] gq, gr; logic gd; int lat, bc;
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done got=%b exp=0", done); end
    n_cmp++; if (q !== 32'h0) begin n_err++; $display("FAIL midrst_q got=%h exp=0", q); end
    n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL midrst_r got=%h exp=0", r); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_stays_idle got=%b exp=0", done); end
    do_div(32'd100, 32'd7, 1'b0, gq, gr, gd, lat, bc);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL midrst_relaunch_latency got=%0d exp=33", lat); end
    n_cmp++; if (gq !== 32'd14) begin n_err++; $display("FAIL midrst_relaunch_q got=%h exp=%h", gq, 32'd14); end
    n_cmp++; if (gr !== 32'd2) begin n_err++; $display("FAIL midrst_relaunch_r got=%h exp=2", gr); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_divu();
    test_signed();
    test_boundary();
    test_div_by_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
